mem_io_bus: RTL and testbench

Memory and I/O bus stage that sits directly downstream of the CPU's memory port. It consumes `mem_cmd`, `mem_addr` and `write_data`, and returns `read_data`. It contains a 256×16 synchronous RAM, an 8-bit LED output register and a 2-flop synchronised switch input port, all decoded from a 9-bit address. Every read response is registered with a fixed 1-cycle latency; a sticky error flag records illegal accesses.

---
 rtl/mem_io_bus_if.sv | 28 ++
 rtl/mem_io_bus.sv | 100 ++++++++++
 tb/tb_mem_io_bus.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_io_bus_if.sv
// rtl/mem_io_bus_if.sv - CPU memory-port bus between requester and mem_io_bus
// Command/address/store data flow downstream; registered read response flows back.
interface mem_io_bus_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  rd_valid
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output rd_valid
    );
endinterface

// File: rtl/mem_io_bus.sv
// rtl/mem_io_bus.sv - memory/I-O bus stage: 256x16 RAM, LED register, synchronised switches
// Single-cycle registered read response; sticky bus_err flags illegal commands and bad accesses.
module mem_io_bus #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 9,
    parameter int                RAM_WORDS = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
    input  logic           clk,
    input  logic           reset,
    mem_io_bus_if.slave    bus,
    input  logic [7:0]     SW,
    output logic [7:0]     LEDR,
    output logic           bus_err
);
    localparam int IDX_W = $clog2(RAM_WORDS);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_ILL   = 2'b11;

    logic [DATA_W-1:0] mem [RAM_WORDS];

    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              rd_valid_q,  rd_valid_d;
    logic [7:0]        led_q,       led_d;
    logic              err_q,       err_d;
    logic [7:0]        sw_s1_q, sw_s2_q;

    logic              ram_hit, led_hit, sw_hit;
    logic              is_rd, is_wr, ram_we;
    logic [IDX_W-1:0]  ram_idx;

    assign ram_hit = ~bus.mem_addr[ADDR_W-1];
    assign led_hit = (bus.mem_addr == LED_ADDR);
    assign sw_hit  = (bus.mem_addr == SW_ADDR);
    assign ram_idx = bus.mem_addr[IDX_W-1:0];
    assign is_rd   = (bus.mem_cmd == CMD_READ);
    assign is_wr   = (bus.mem_cmd == CMD_WRITE);
    assign ram_we  = is_wr & ram_hit;

    always_comb begin
        read_data_d = read_data_q;
        rd_valid_d  = 1'b0;
        led_d       = led_q;
        err_d       = err_q;

        if (is_rd) begin
            rd_valid_d = 1'b1;
            if (ram_hit) begin
                read_data_d = mem[ram_idx];
            end else if (sw_hit) begin
                read_data_d = {{(DATA_W-8){1'b0}}, sw_s2_q};
            end else begin
                // LED is write-only, so reading it is as bad as an unmapped read
                read_data_d = '0;
                err_d       = 1'b1;
            end
        end else if (is_wr) begin
            if (led_hit) begin
                led_d = bus.write_data[7:0];
            end else if (!ram_hit) begin
                err_d = 1'b1;
            end
        end else if (bus.mem_cmd == CMD_ILL) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q <= '0;
            rd_valid_q  <= 1'b0;
            led_q       <= 8'h00;
            err_q       <= 1'b0;
            sw_s1_q     <= 8'h00;
            sw_s2_q     <= 8'h00;
        end else begin
            read_data_q <= read_data_d;
            rd_valid_q  <= rd_valid_d;
            led_q       <= led_d;
            err_q       <= err_d;
            sw_s1_q     <= SW;
            sw_s2_q     <= sw_s1_q;
        end
    end

    // RAM deliberately outside the reset domain: contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= bus.write_data;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign LEDR          = led_q;
    assign bus_err       = err_q;
endmodule

// File: tb/tb_mem_io_bus.sv
// tb/tb_mem_io_bus.sv - directed table-driven bench for mem_io_bus
// Table vectors cover the main data path; hand sequences cover reset and error corners.
module tb_mem_io_bus;
    logic       clk;
    logic       reset;
    logic [7:0] SW;
    logic [7:0] LEDR;
    logic       bus_err;

    int checks = 0;
    int errors = 0;

    mem_io_bus_if #(.DATA_W(16), .ADDR_W(9)) bus ();

    mem_io_bus dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .SW      (SW),
        .LEDR    (LEDR),
        .bus_err (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WR   = 2'b10;
    localparam logic [1:0] ILL  = 2'b11;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [7:0]  sw;
        logic [15:0] exp_rd;
        logic        exp_v;
        logic [7:0]  exp_led;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [15:0] rd, input logic v,
                            input logic [7:0] led, input logic err);
        chk({name, ".read_data"}, {16'h0, bus.read_data}, {16'h0, rd});
        chk({name, ".rd_valid"},  {31'h0, bus.rd_valid},  {31'h0, v});
        chk({name, ".LEDR"},      {24'h0, LEDR},          {24'h0, led});
        chk({name, ".bus_err"},   {31'h0, bus_err},       {31'h0, err});
    endtask

    // Called at a negedge: drive, let one posedge pass, return at the next negedge
    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = d;
        @(negedge clk);
    endtask

    task automatic add(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                       input logic [7:0] s, input logic [15:0] rd, input logic v,
                       input logic [7:0] led, input logic err);
        vecs.push_back('{c, a, d, s, rd, v, led, err});
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        SW             = 8'h00;
        bus.mem_cmd    = NONE;
        bus.mem_addr   = '0;
        bus.write_data = '0;
        #1;
        chk_outs("reset0", 16'h0000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        //   cmd   addr    wdata    sw     exp_rd   v     led    err
        add(WR,   9'h006, 16'h0606, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
        add(WR,   9'h005, 16'hBEEF, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
        add(RD,   9'h005, 16'h0000, 8'h00, 16'hBEEF, 1'b1, 8'h00, 1'b0);
        add(RD,   9'h006, 16'h0000, 8'h00, 16'h0606, 1'b1, 8'h00, 1'b0);
        add(NONE, 9'h005, 16'h0000, 8'h00, 16'h0606, 1'b0, 8'h00, 1'b0);
        add(WR,   9'h010, 16'h1111, 8'h00, 16'h0606, 1'b0, 8'h00, 1'b0);
        add(WR,   9'h011, 16'h2222, 8'h00, 16'h0606, 1'b0, 8'h00, 1'b0);
        add(WR,   9'h012, 16'h3333, 8'h00, 16'h0606, 1'b0, 8'h00, 1'b0);
        add(RD,   9'h010, 16'h0000, 8'h00, 16'h1111, 1'b1, 8'h00, 1'b0);
        add(RD,   9'h011, 16'h0000, 8'h00, 16'h2222, 1'b1, 8'h00, 1'b0);
        add(RD,   9'h012, 16'h0000, 8'h00, 16'h3333, 1'b1, 8'h00, 1'b0);
        add(NONE, 9'h000, 16'h0000, 8'h00, 16'h3333, 1'b0, 8'h00, 1'b0);
        add(WR,   9'h100, 16'h12C3, 8'h00, 16'h3333, 1'b0, 8'hC3, 1'b0);
        add(NONE, 9'h000, 16'h0000, 8'h5A, 16'h3333, 1'b0, 8'hC3, 1'b0);
        add(NONE, 9'h000, 16'h0000, 8'h5A, 16'h3333, 1'b0, 8'hC3, 1'b0);
        add(RD,   9'h140, 16'h0000, 8'h5A, 16'h005A, 1'b1, 8'hC3, 1'b0);
        add(RD,   9'h006, 16'h0000, 8'h5A, 16'h0606, 1'b1, 8'hC3, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            SW = vecs[i].sw;
            step(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_v,
                     vecs[i].exp_led, vecs[i].exp_err);
        end

        // Write to read-only switch port: only bus_err changes
        step(WR, 9'h140, 16'hFFFF);
        chk_outs("wr_sw", 16'h0606, 1'b0, 8'hC3, 1'b1);

        // Mid-cycle reset clears outputs immediately
        step(WR, 9'h100, 16'h00AA);
        chk_outs("led_aa", 16'h0606, 1'b0, 8'hAA, 1'b1);
        bus.mem_cmd = NONE;
        #2 reset = 1'b0;
        #1;
        chk_outs("async_rst", 16'h0000, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Unmapped read returns zero with a valid pulse and flags error
        step(RD, 9'h005, 16'h0);
        chk_outs("rd_ram", 16'hBEEF, 1'b1, 8'h00, 1'b0);
        step(RD, 9'h1FF, 16'h0);
        chk_outs("rd_unmapped", 16'h0000, 1'b1, 8'h00, 1'b1);
        step(NONE, 9'h0, 16'h0);

        // Illegal command after reset
        do_reset();
        step(RD, 9'h005, 16'h0);
        chk_outs("rd_pre_ill", 16'hBEEF, 1'b1, 8'h00, 1'b0);
        step(ILL, 9'h005, 16'h0);
        chk_outs("illegal", 16'hBEEF, 1'b0, 8'h00, 1'b1);

        // Reset arrives between a READ being presented and its sampling edge
        do_reset();
        bus.mem_cmd  = RD;
        bus.mem_addr = 9'h005;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_rd.valid_in_reset", {31'h0, bus.rd_valid}, 32'h0);
        @(negedge clk);
        bus.mem_cmd = NONE;
        reset = 1'b1;
        chk("rst_rd.valid_release", {31'h0, bus.rd_valid}, 32'h0);
        @(negedge clk);
        chk_outs("rst_rd.after", 16'h0000, 1'b0, 8'h00, 1'b0);
        step(RD, 9'h005, 16'h0);
        chk_outs("rst_rd.persist", 16'hBEEF, 1'b1, 8'h00, 1'b0);
        step(NONE, 9'h0, 16'h0);
        chk_outs("rst_rd.none", 16'hBEEF, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
